cmp_arb_sched: RTL and testbench
================================

# cmp_arb_sched

Round-robin scheduler that shares a single 6-bit equality/inequality comparator among four requesters. Each requester presents two operands and a mode bit (0 = test equal, 1 = test not-equal) and holds a request. The block grants one requester at a time, latches its operands, runs them through the comparator core, and returns a registered 1-bit result with a one-cycle acknowledge. It sits between the requesting control units and the shared comparison datapath.

## Interface
- `N_REQ`, 4: number of requesters; fixed at 4 for this release, so `grant_id` is 2 bits.
- `WIDTH`, 6: operand width.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `req`  in  N_REQ  per-requester request, level-sensitive.
- `a_in`  in  N_REQ*WIDTH  flattened operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- `b_in`  in  N_REQ*WIDTH  flattened operand B, same packing as `a_in`.
- `sel_in`  in  N_REQ  per-requester mode: 0 = output 1 when A==B; 1 = output 1 when A!=B.
- `ack`  out  N_REQ  one-hot; pulses high for exactly one cycle to the served requester.
- `result`  out  1  comparison result; valid only while any `ack` bit is high.
- `grant_id`  out  2  index of the requester currently being served or last served.
- `busy`  out  1  high while state ≠ IDLE.

## Operation
- FSM states are IDLE, CMP and DONE.
- IDLE:
  - If `req` ≠ 0, choose the winner by round-robin starting at `ptr`.
  - Latch `a`, `b`, `sel` and `grant_id` for the winner.
  - Go to CMP.
  - If `req` == 0, stay in IDLE.
- CMP: register the comparator output (A==B when sel=0; A!=B when sel=1) into `result`, then go to DONE.
- DONE:
  - `ack[grant_id]` = 1 and `result` is held.
  - Set `ptr` ← (`grant_id` + 1) mod 4.
  - Go to IDLE unconditionally.
- Round-robin order: check `ptr`, `ptr`+1, … `ptr`+3, all mod 4. The first requester with `req` set wins.
- Operands are captured at grant. Requesters may change operands or drop `req` after the grant edge; the in-flight comparison still completes and `ack` is still issued.
- A requester must deassert `req` in the cycle after its `ack`. Otherwise its request is treated as a new one, and it is served again only after the other pending requesters, because `ptr` has advanced past it.
- `result` and `grant_id` hold their values from DONE until the next CMP or grant update.

## Timing
- Reset values: state = IDLE, `ptr` = 0, `ack` = 0, `result` = 0, `grant_id` = 0, `busy` = 0, latched operands = 0.
- Latency: `req` sampled at edge T (IDLE) → CMP after T → result registered at T+1 → `ack` and `result` valid during the cycle after T+1, i.e. the third cycle counted from the sampling cycle.
- Throughput: one comparison every 3 cycles under continuous requests.
- `busy` rises the cycle after the grant edge and falls after the DONE cycle.
- Simultaneous requests: exactly one grant per IDLE visit. There are no back-to-back grants without passing through IDLE.
- `ptr` wraps from 3 to 0.
- Reset asserted in CMP or DONE: outputs clear asynchronously, no `ack` is issued, and the in-flight request is lost. After release, the requester must still be holding `req` to be served.
- Boundary operands: 0x00 vs 0x00 and 0x3F vs 0x3F compare equal. Single-bit differences at bit 0 and bit 5 must both be detected.

## Structure
- Package `cmp_arb_pkg` holds:
  - the state enum (IDLE, CMP, DONE);
  - `WIDTH` = 6 and `N_REQ` = 4 defaults;
  - the `GRANT_W` = 2 constant.
- Sub-module `cmp_eq_neq_core` is purely combinational.
  - Inputs: `a`[WIDTH], `b`[WIDTH], `sel`. Output: `s`.
  - It is an XNOR-reduce-AND followed by a sel-controlled invert/mux.
  - It is instantiated once, on the latched operands.
- Top level contains the FSM, the round-robin pointer and winner-selection logic, the operand latches and the result register.

## Test plan
- Reset, then req=0001, a0=0x0F, b0=0x0F, sel0=0 → `ack`=0001 on the 3rd cycle, `result`=1, `grant_id`=0, `busy`=1 for 2 cycles.
- req0 with a0=0x0F, b0=0x0E, sel0=1 → `result`=1. Repeat with sel0=0 → `result`=0. Repeat with 0x00/0x00, sel0=1 → `result`=0.
- req=1111 held continuously → `ack` sequence 0001, 0010, 0100, 1000, 0001, one `ack` every 3 cycles; check the wrap of `ptr` from 3 to 0.
- After serving req1, assert req=0011 → requester 1 waits and requester 0 is granted first (`ptr`=2 wraps to 0), followed by requester 1.
- Requester 2 changes a2 from 0x15 to 0x3F and drops `req` the cycle after the grant, with b2=0x15, sel2=0 → `ack`=0100 still issued, `result`=1 computed on the latched operands.
- `reset` pulsed during CMP → `ack` never asserted, all outputs 0. After release with req3 still held → served normally with `ack`=1000.

Source files
------------

// File: rtl/cmp_arb_pkg.sv
// rtl/cmp_arb_pkg.sv - shared constants and FSM state type for the comparator scheduler
package cmp_arb_pkg;

  localparam int WIDTH   = 6;
  localparam int N_REQ   = 4;
  localparam int GRANT_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/cmp_eq_neq_core.sv
// rtl/cmp_eq_neq_core.sv - combinational equal / not-equal comparator
module cmp_eq_neq_core
  import cmp_arb_pkg::*;
(
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sel_i,
  output logic             s_o
);

  logic eq;

  assign eq  = &(a_i ~^ b_i);
  assign s_o = sel_i ? ~eq : eq;

endmodule

// File: rtl/cmp_arb_sched.sv
// rtl/cmp_arb_sched.sv - round-robin scheduler sharing one comparator among four requesters
module cmp_arb_sched
  import cmp_arb_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [N_REQ-1:0]       req_i,
  input  logic [N_REQ*WIDTH-1:0] a_in_i,
  input  logic [N_REQ*WIDTH-1:0] b_in_i,
  input  logic [N_REQ-1:0]       sel_in_i,
  output logic [N_REQ-1:0]       ack_o,
  output logic                   result_o,
  output logic [GRANT_W-1:0]     grant_id_o,
  output logic                   busy_o
);

  state_e             state_q;
  logic [GRANT_W-1:0] ptr_q;
  logic [GRANT_W-1:0] grant_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               sel_q;
  logic               result_q;
  logic [N_REQ-1:0]   ack_q;

  logic               win_valid_d;
  logic [GRANT_W-1:0] win_d;
  logic [GRANT_W-1:0] idx;
  logic               cmp_s;

  // First requester found scanning upward from ptr, wrapping mod 4
  always_comb begin
    win_valid_d = 1'b0;
    win_d       = '0;
    idx         = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = ptr_q + GRANT_W'(k);
      if (!win_valid_d && req_i[idx]) begin
        win_valid_d = 1'b1;
        win_d       = idx;
      end
    end
  end

  cmp_eq_neq_core u_core (
    .a_i   (a_q),
    .b_i   (b_q),
    .sel_i (sel_q),
    .s_o   (cmp_s)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      grant_q  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sel_q    <= 1'b0;
      result_q <= 1'b0;
      ack_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          ack_q <= '0;
          if (win_valid_d) begin
            grant_q <= win_d;
            a_q     <= a_in_i[win_d*WIDTH +: WIDTH];
            b_q     <= b_in_i[win_d*WIDTH +: WIDTH];
            sel_q   <= sel_in_i[win_d];
            state_q <= CMP;
          end
        end
        CMP: begin
          result_q <= cmp_s;
          ack_q    <= N_REQ'(1) << grant_q;
          state_q  <= DONE;
        end
        DONE: begin
          ack_q   <= '0;
          ptr_q   <= grant_q + GRANT_W'(1);
          state_q <= IDLE;
        end
        default: begin
          ack_q   <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ack_o      = ack_q;
  assign result_o   = result_q;
  assign grant_id_o = grant_q;
  assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_cmp_arb_sched.sv
// tb/tb_cmp_arb_sched.sv - directed self-checking bench for cmp_arb_sched
module tb_cmp_arb_sched;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [23:0] a_in;
  logic [23:0] b_in;
  logic [3:0]  sel_in;
  logic [3:0]  ack;
  logic        result;
  logic [1:0]  grant_id;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  cmp_arb_sched dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .req_i      (req),
    .a_in_i     (a_in),
    .b_in_i     (b_in),
    .sel_in_i   (sel_in),
    .ack_o      (ack),
    .result_o   (result),
    .grant_id_o (grant_id),
    .busy_o     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [5:0] a, input logic [5:0] b, input logic s);
    a_in[i*6 +: 6] = a;
    b_in[i*6 +: 6] = b;
    sel_in[i]      = s;
  endtask

  // Single requester, starting in IDLE; ends back in IDLE with req cleared
  task automatic run_one(input string tag, input int i, input logic [5:0] a,
                         input logic [5:0] b, input logic s, input logic exp_res);
    set_ops(i, a, b, s);
    req = 4'(1 << i);
    tick();
    tick();
    check({tag, "_ack"}, 32'(ack), 32'(1 << i));
    check({tag, "_res"}, 32'(result), 32'(exp_res));
    check({tag, "_gid"}, 32'(grant_id), 32'(i));
    req = 4'b0000;
    tick();
  endtask

  initial begin
    reset  = 1'b1;
    req    = '0;
    a_in   = '0;
    b_in   = '0;
    sel_in = '0;
    tick();
    tick();
    check("rst_ack",  32'(ack), 0);
    check("rst_res",  32'(result), 0);
    check("rst_gid",  32'(grant_id), 0);
    check("rst_busy", 32'(busy), 0);
    reset = 1'b0;
    tick();

    // Basic latency: ack on the third cycle, busy for two cycles
    set_ops(0, 6'h0F, 6'h0F, 1'b0);
    req = 4'b0001;
    check("lat_c1_busy", 32'(busy), 0);
    tick();
    check("lat_c2_busy", 32'(busy), 1);
    check("lat_c2_ack",  32'(ack), 0);
    tick();
    check("lat_c3_ack",  32'(ack), 32'h1);
    check("lat_c3_res",  32'(result), 1);
    check("lat_c3_gid",  32'(grant_id), 0);
    check("lat_c3_busy", 32'(busy), 1);
    req = 4'b0000;
    tick();
    check("lat_c4_ack",  32'(ack), 0);
    check("lat_c4_busy", 32'(busy), 0);
    check("lat_c4_hold", 32'(result), 1);

    run_one("ne_diff",  0, 6'h0F, 6'h0E, 1'b1, 1'b1);
    run_one("eq_diff",  0, 6'h0F, 6'h0E, 1'b0, 1'b0);
    run_one("ne_zero",  0, 6'h00, 6'h00, 1'b1, 1'b0);
    run_one("eq_ones",  1, 6'h3F, 6'h3F, 1'b0, 1'b1);
    run_one("eq_bit0",  2, 6'h3F, 6'h3E, 1'b0, 1'b0);
    run_one("ne_bit5",  3, 6'h00, 6'h20, 1'b1, 1'b1);
    run_one("eq_zero",  1, 6'h00, 6'h00, 1'b0, 1'b1);
    run_one("ne_bit0",  3, 6'h2A, 6'h2B, 1'b1, 1'b1);

    // Continuous requests: last served was 3, so ptr is 0
    for (int i = 0; i < 4; i++) set_ops(i, 6'(i), 6'(i), 1'b0);
    req = 4'b1111;
    tick();
    tick();
    check("rr0_ack", 32'(ack), 32'h1);
    tick();
    check("rr_gap_ack", 32'(ack), 0);
    tick();
    check("rr_gap_busy", 32'(busy), 1);
    tick();
    check("rr1_ack", 32'(ack), 32'h2);
    tick(); tick(); tick();
    check("rr2_ack", 32'(ack), 32'h4);
    tick(); tick(); tick();
    check("rr3_ack", 32'(ack), 32'h8);
    check("rr3_gid", 32'(grant_id), 3);
    tick(); tick(); tick();
    check("rr_wrap_ack", 32'(ack), 32'h1);
    check("rr_wrap_gid", 32'(grant_id), 0);
    check("rr_wrap_res", 32'(result), 1);
    req = 4'b0000;
    tick();

    // After serving 1 (ptr=2), requester 0 beats requester 1
    run_one("pre1", 1, 6'h05, 6'h05, 1'b0, 1'b1);
    set_ops(0, 6'h11, 6'h12, 1'b1);
    set_ops(1, 6'h11, 6'h11, 1'b1);
    req = 4'b0011;
    tick();
    tick();
    check("p01_ack0", 32'(ack), 32'h1);
    check("p01_res0", 32'(result), 1);
    req = 4'b0010;
    tick(); tick(); tick();
    check("p01_ack1", 32'(ack), 32'h2);
    check("p01_res1", 32'(result), 0);
    req = 4'b0000;
    tick();

    // Operands captured at grant: later changes and req drop do not matter
    set_ops(2, 6'h15, 6'h15, 1'b0);
    req = 4'b0100;
    tick();
    a_in[12 +: 6] = 6'h3F;
    req = 4'b0000;
    tick();
    check("latch_ack", 32'(ack), 32'h4);
    check("latch_res", 32'(result), 1);
    tick();

    // Reset mid-comparison: no ack, outputs cleared, request re-served after release
    set_ops(3, 6'h2A, 6'h2A, 1'b0);
    req = 4'b1000;
    tick();
    check("mid_busy", 32'(busy), 1);
    reset = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 0);
    check("arst_ack",  32'(ack), 0);
    check("arst_res",  32'(result), 0);
    check("arst_gid",  32'(grant_id), 0);
    tick();
    tick();
    check("arst_hold_ack", 32'(ack), 0);
    reset = 1'b0;
    tick();
    tick();
    check("post_rst_ack", 32'(ack), 32'h8);
    check("post_rst_res", 32'(result), 1);
    check("post_rst_gid", 32'(grant_id), 3);
    req = 4'b0000;
    tick();
    check("final_busy", 32'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
